// File: rtl/riscv_ctrl_bpred.sv
// Branch prediction and redirect controller.
// Direct-mapped BTB with 2-bit direction counters. It gives a same-cycle
// prediction for the fetch PC. It checks each resolved control transfer in EX
// against the prediction that instruction carried, and on a mismatch raises a
// registered one-cycle flush with the corrected PC.
// Ports:
//   iclk, irst                     clock, synchronous active-high reset
//   ifetch_pc                      fetch PC to look up
//   opred_taken, opred_target      combinational prediction for ifetch_pc
//   iex_valid, iex_op, iex_pc      instruction in EX
//   iex_taken, iex_target          resolved direction and target
//   iex_pred_taken/_target         prediction carried with the EX instruction
//   oflush, oredirect_pc           registered mispredict redirect
module riscv_ctrl_bpred #(
    parameter int unsigned P_IDX_W = 6
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic [31:0] ifetch_pc,
    output logic        opred_taken,
    output logic [31:0] opred_target,
    input  logic        iex_valid,
    input  logic [6:0]  iex_op,
    input  logic [31:0] iex_pc,
    input  logic        iex_taken,
    input  logic [31:0] iex_target,
    input  logic        iex_pred_taken,
    input  logic [31:0] iex_pred_target,
    output logic        oflush,
    output logic [31:0] oredirect_pc
);

    localparam int unsigned ENTRIES = 2 ** P_IDX_W;
    localparam int unsigned TAG_W   = 32 - P_IDX_W - 2;

    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [ENTRIES-1:0] jump_q, jump_d;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic               flush_q, flush_d;
    logic [31:0]        redirect_q, redirect_d;

    logic [P_IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0]   f_tag, e_tag;
    logic               f_hit, e_hit, pred_taken;
    logic               is_br, is_jmp, res, mispred;

    // Address bits [1:0] are always zero for 32-bit instructions.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{ifetch_pc[1:0], iex_pc[1:0]};

    // Fetch-side lookup from registered state only.
    always_comb begin
        f_idx      = ifetch_pc[P_IDX_W+1:2];
        f_tag      = ifetch_pc[31:P_IDX_W+2];
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken = f_hit && (jump_q[f_idx] || ctr_q[f_idx][1]);
    end

    assign opred_taken  = pred_taken;
    assign opred_target = pred_taken ? target_q[f_idx] : 32'd0;
    assign oflush       = flush_q;
    assign oredirect_pc = redirect_q;

    // Resolve qualification; the EX slot during a flush is wrong-path.
    always_comb begin
        e_idx   = iex_pc[P_IDX_W+1:2];
        e_tag   = iex_pc[31:P_IDX_W+2];
        e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        is_br   = (iex_op == OP_BRANCH);
        is_jmp  = (iex_op == OP_JALR) || (iex_op == OP_JAL);
        res     = iex_valid && !flush_q && (is_br || is_jmp);
        mispred = res && ((iex_taken != iex_pred_taken) ||
                          (iex_taken && (iex_pred_target != iex_target)));
        flush_d    = mispred;
        redirect_d = mispred ? (iex_taken ? iex_target : iex_pc + 32'd4) : 32'd0;
    end

    // BTB update at the EX index.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        jump_d   = jump_q;
        ctr_d    = ctr_q;
        if (res) begin
            if (e_hit) begin
                if (is_br) begin
                    if (iex_taken) begin
                        target_d[e_idx] = iex_target;
                        if (ctr_q[e_idx] != 2'd3) ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                    end else if (ctr_q[e_idx] != 2'd0) begin
                        ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                    end
                end else begin
                    target_d[e_idx] = iex_target;
                    jump_d[e_idx]   = 1'b1;
                    ctr_d[e_idx]    = 2'd3;
                end
            end else if (iex_taken) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = iex_target;
                jump_d[e_idx]   = is_jmp;
                ctr_d[e_idx]    = is_jmp ? 2'd3 : 2'd2;
            end
        end
    end

    // Control state with reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            valid_q    <= '0;
            flush_q    <= 1'b0;
            redirect_q <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    // Entry payload; qualified by valid so no reset needed.
    always_ff @(posedge iclk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        jump_q   <= jump_d;
        ctr_q    <= ctr_d;
    end

endmodule

// File: tb/tb_riscv_ctrl_bpred.sv
// Directed, table-driven bench for riscv_ctrl_bpred. Each table row is one
// cycle: inputs are driven after the falling edge and outputs are checked
// before the next rising edge. The expected flush in a row therefore belongs
// to the resolve in the previous row.
module tb_riscv_ctrl_bpred;

    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] ALU  = 7'h33;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic [31:0] ifetch_pc = '0;
    logic        opred_taken;
    logic [31:0] opred_target;
    logic        iex_valid = 1'b0;
    logic [6:0]  iex_op = '0;
    logic [31:0] iex_pc = '0;
    logic        iex_taken = 1'b0;
    logic [31:0] iex_target = '0;
    logic        iex_pred_taken = 1'b0;
    logic [31:0] iex_pred_target = '0;
    logic        oflush;
    logic [31:0] oredirect_pc;

    riscv_ctrl_bpred #(.P_IDX_W(6)) dut (
        .iclk(iclk), .irst(irst), .ifetch_pc(ifetch_pc),
        .opred_taken(opred_taken), .opred_target(opred_target),
        .iex_valid(iex_valid), .iex_op(iex_op), .iex_pc(iex_pc),
        .iex_taken(iex_taken), .iex_target(iex_target),
        .iex_pred_taken(iex_pred_taken), .iex_pred_target(iex_pred_target),
        .oflush(oflush), .oredirect_pc(oredirect_pc)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [31:0] fpc;
        logic        v;
        logic [6:0]  op;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        ept;
        logic [31:0] eptgt;
        logic        efl;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic add(input logic [31:0] fpc, input logic v, input logic [6:0] op,
                       input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic ept, input logic [31:0] eptgt,
                       input logic efl, input logic [31:0] erd);
        vec_t r;
        r.fpc = fpc; r.v = v; r.op = op; r.pc = pc; r.tk = tk; r.tgt = tgt;
        r.ptk = ptk; r.ptgt = ptgt; r.ept = ept; r.eptgt = eptgt;
        r.efl = efl; r.erd = erd;
        vecs.push_back(r);
    endtask

    // Idle cycle: fetch only, nothing valid in EX.
    task automatic idle(input logic [31:0] fpc, input logic ept, input logic [31:0] eptgt,
                        input logic efl, input logic [31:0] erd);
        add(fpc, 1'b0, ALU, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, ept, eptgt, efl, erd);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input vec_t r);
        ifetch_pc       = r.fpc;
        iex_valid       = r.v;
        iex_op          = r.op;
        iex_pc          = r.pc;
        iex_taken       = r.tk;
        iex_target      = r.tgt;
        iex_pred_taken  = r.ptk;
        iex_pred_target = r.ptgt;
    endtask

    task automatic check_row(input vec_t r, input int idx);
        chk("pred_taken", idx, 32'(opred_taken), 32'(r.ept));
        chk("pred_target", idx, opred_target, r.eptgt);
        chk("flush", idx, 32'(oflush), 32'(r.efl));
        if (r.efl) chk("redirect_pc", idx, oredirect_pc, r.erd);
    endtask

    initial begin
        // Counter training on the branch at 0x100.
        idle(32'h100, 0, 0, 0, 0);
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 0,      0, 0, 0, 0);       // miss, alloc ctr=2
        idle(32'h100, 1, 32'h80, 1, 32'h80);
        add(32'h100, 1, BR, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 0, 0);  // ctr 2->1, flush
        idle(32'h100, 0, 0, 1, 32'h104);
        add(32'h100, 1, BR, 32'h100, 0, 32'h80, 0, 0,      0, 0, 0, 0);       // 1->0
        add(32'h100, 1, BR, 32'h100, 0, 32'h80, 0, 0,      0, 0, 0, 0);       // stays 0
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 1, 32'h80, 0, 0, 0, 0);       // 0->1
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 1, 32'h80, 0, 0, 0, 0);       // 1->2
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 0);  // 2->3
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 0);  // stays 3
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 0);  // stays 3
        add(32'h100, 1, BR, 32'h100, 0, 32'h80, 0, 0,      1, 32'h80, 0, 0);  // 3->2
        idle(32'h100, 1, 32'h80, 0, 0);
        // JALR at 0x200 (same index as 0x100): allocate, then target change.
        add(32'h200, 1, JALR, 32'h200, 1, 32'h400, 0, 0,       0, 0, 0, 0);
        idle(32'h200, 1, 32'h400, 1, 32'h400);
        add(32'h200, 1, JALR, 32'h200, 1, 32'h500, 1, 32'h400, 1, 32'h400, 0, 0);
        idle(32'h200, 1, 32'h500, 1, 32'h500);
        idle(32'h100, 0, 0, 0, 0);
        // Mispredict followed by a would-be mispredict in the flush cycle.
        add(32'h340, 1, BR, 32'h340, 1, 32'h1000, 0, 0,        0, 0, 0, 0);
        add(32'h340, 1, BR, 32'h340, 0, 32'h1000, 1, 32'h1000, 1, 32'h1000, 1, 32'h1000);
        idle(32'h340, 1, 32'h1000, 0, 0);
        idle(32'h340, 1, 32'h1000, 0, 0);
        // Not-taken mispredict at the top of the address space wraps to 0.
        add(32'hFFFF_FFFC, 1, BR, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10, 0, 0, 0, 0);
        idle(32'hFFFF_FFFC, 0, 0, 1, 32'h0);
        // Non-control opcode and invalid EX slot: no flush, no allocation.
        add(32'h400, 1, ALU, 32'h400, 1, 32'h800, 0, 0, 0, 0, 0, 0);
        idle(32'h400, 0, 0, 0, 0);
        add(32'h440, 0, BR, 32'h440, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        idle(32'h440, 0, 0, 0, 0);
        // JAL allocation.
        add(32'h480, 1, JAL, 32'h480, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
        idle(32'h480, 1, 32'h2000, 1, 32'h2000);
        // Aliasing: 0x200 = 0x100 + 4*64 retags index 0; same-cycle lookup sees old entry.
        add(32'h100, 1, BR, 32'h100, 1, 32'h80, 0, 0, 0, 0, 0, 0);
        idle(32'h100, 1, 32'h80, 1, 32'h80);
        add(32'h100, 1, BR, 32'h200, 1, 32'h600, 0, 0, 1, 32'h80, 0, 0);
        idle(32'h100, 0, 0, 1, 32'h600);
        idle(32'h200, 1, 32'h600, 0, 0);

        // Reset and reset-state checks.
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        irst = 1'b0;
        ifetch_pc = 32'h100;
        #1;
        chk("reset_flush", -1, 32'(oflush), 32'd0);
        chk("reset_redirect", -1, oredirect_pc, 32'd0);
        chk("reset_pred", -1, 32'(opred_taken), 32'd0);

        foreach (vecs[i]) begin
            @(negedge iclk);
            drive(vecs[i]);
            #1;
            check_row(vecs[i], i);
        end

        // Reset sampled in the same cycle as a mispredicting resolve.
        @(negedge iclk);
        ifetch_pc = 32'h340;
        iex_valid = 1'b1; iex_op = BR; iex_pc = 32'h340; iex_taken = 1'b0;
        iex_target = 32'h1000; iex_pred_taken = 1'b1; iex_pred_target = 32'h1000;
        irst = 1'b1;
        #1;
        chk("pre_rst_pred", 100, 32'(opred_taken), 32'd1);
        @(negedge iclk);
        irst = 1'b0;
        iex_valid = 1'b0;
        #1;
        chk("rst_flush_dropped", 101, 32'(oflush), 32'd0);
        chk("rst_miss_340", 101, 32'(opred_taken), 32'd0);
        ifetch_pc = 32'h200;
        #1;
        chk("rst_miss_200", 102, 32'(opred_taken), 32'd0);
        ifetch_pc = 32'h480;
        #1;
        chk("rst_miss_480", 103, 32'(opred_taken), 32'd0);
        chk("rst_miss_480_tgt", 103, opred_target, 32'd0);
        @(negedge iclk);
        #1;
        chk("rst_flush_after", 104, 32'(oflush), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
